// File: rtl/posit_pkg.sv
// Shared types and helpers for the posit round/pack pipeline.
// Word-sized helpers return MAX_N bits; callers slice the low N bits.
package posit_pkg;

    localparam int MAX_N = 64;

    // Everything stage 2 needs besides the N-1 bit body.
    typedef struct packed {
        logic sign;
        logic zero;
        logic nar;
        logic sat;
        logic guard;
        logic sticky;
    } s1_flags_t;

    function automatic int regime_len(input int k);
        return (k >= 0) ? k + 2 : 1 - k;
    endfunction

    function automatic logic [MAX_N-1:0] maxpos_word(input int n);
        return (MAX_N'(1) << (n - 1)) - MAX_N'(1);
    endfunction

    function automatic logic [MAX_N-1:0] minpos_word(input int n);
        return (n > 1) ? MAX_N'(1) : MAX_N'(0);
    endfunction

    function automatic logic [MAX_N-1:0] nar_word(input int n);
        return MAX_N'(1) << (n - 1);
    endfunction

endpackage

// File: rtl/posit_round_pack_if.sv
// Valid/ready bus between the posit normaliser and the round/pack stage.
// master = upstream/downstream environment, slave = posit_round_pack.
interface posit_round_pack_if #(
    parameter int N  = 32,
    parameter int ES = 3,
    parameter int FW = 64,
    parameter int KW = 8
);
    localparam int ESW = (ES > 0) ? ES : 1;

    logic           in_valid;
    logic           in_ready;
    logic           in_sign;
    logic           in_zero;
    logic           in_nar;
    logic [KW-1:0]  in_k;
    logic [ESW-1:0] in_exp;
    logic [FW-1:0]  in_frac;
    logic           in_sticky;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_posit;
    logic           out_inexact;
    logic           out_sat;

    modport master (
        output in_valid, in_sign, in_zero, in_nar, in_k, in_exp, in_frac, in_sticky,
        output out_ready,
        input  in_ready, out_valid, out_posit, out_inexact, out_sat
    );

    modport slave (
        input  in_valid, in_sign, in_zero, in_nar, in_k, in_exp, in_frac, in_sticky,
        input  out_ready,
        output in_ready, out_valid, out_posit, out_inexact, out_sat
    );
endinterface

// File: rtl/posit_rne_round.sv
// Combinational round-to-nearest-even, carry clamp and sign negation of a
// stage-1 payload into the final N-bit posit word.
module posit_rne_round
    import posit_pkg::*;
#(
    parameter int N = 32
) (
    input  s1_flags_t      flags,
    input  logic [N-2:0]   body,
    output logic [N-1:0]   posit,
    output logic           inexact,
    output logic           sat
);
    localparam logic [MAX_N-1:0] MAXPOS_W = maxpos_word(N);
    localparam logic [MAX_N-1:0] NAR_W    = nar_word(N);

    logic         round_up;
    logic         carry;
    logic [N-1:0] sum;
    logic [N-1:0] mag;

    always_comb begin
        round_up = flags.guard & (body[0] | flags.sticky);
        sum      = {1'b0, body} + {{(N-1){1'b0}}, round_up};
        carry    = sum[N-1];
        // A carry out of the body would reach the NaR pattern; pin it at maxpos.
        mag      = carry ? MAXPOS_W[N-1:0] : sum;
        posit    = flags.sign ? (~mag + 1'b1) : mag;
        sat      = flags.sat | carry;
        inexact  = flags.guard | flags.sticky | sat;
        if (flags.nar) begin
            posit   = NAR_W[N-1:0];
            inexact = 1'b0;
            sat     = 1'b0;
        end else if (flags.zero) begin
            posit   = '0;
            inexact = 1'b0;
            sat     = 1'b0;
        end
    end
endmodule

// File: rtl/posit_round_pack.sv
// Two-stage valid/ready pipeline packing a decoded posit into an N-bit word:
// stage 1 lays out regime/exponent/fraction, stage 2 rounds and negates.
module posit_round_pack
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 3,
    parameter int FW = 64,
    parameter int KW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    posit_round_pack_if.slave bus
);
    localparam int TW = ES + FW;
    localparam int LW = N + TW;
    localparam logic [MAX_N-1:0] MAXPOS_W = maxpos_word(N);
    localparam logic [MAX_N-1:0] MINPOS_W = minpos_word(N);

    logic            s1_valid_reg;
    s1_flags_t       s1_flags_reg;
    s1_flags_t       s1_flags_next;
    logic [N-2:0]    s1_body_reg;
    logic [N-2:0]    s1_body_next;
    logic            out_valid_reg;
    logic [N-1:0]    out_posit_reg;
    logic            out_inexact_reg;
    logic            out_sat_reg;
    logic [N-1:0]    out_posit_next;
    logic            out_inexact_next;
    logic            out_sat_next;
    logic            s1_load;
    logic            s2_load;

    logic [TW-1:0]   tail;
    logic [LW-1:0]   base_vec;
    logic [LW-1:0]   shifted_vec;
    logic [LW-1:0]   run_mask;
    int              k_int;
    int              run_len;
    logic            sat_hi;
    logic            sat_lo;

    assign s2_load = !out_valid_reg || bus.out_ready;
    assign s1_load = !s1_valid_reg || s2_load;

    assign bus.in_ready    = s1_load;
    assign bus.out_valid   = out_valid_reg;
    assign bus.out_posit   = out_posit_reg;
    assign bus.out_inexact = out_inexact_reg;
    assign bus.out_sat     = out_sat_reg;

    generate
        if (ES > 0) begin : g_exp
            assign tail = {bus.in_exp[ES-1:0], bus.in_frac};
        end else begin : g_noexp
            assign tail = bus.in_frac;
        end
    endgenerate

    // The terminator bit leads the tail; shifting by the run length opens room
    // for the regime run, which is all zeros (k<0) or filled with ones (k>=0).
    always_comb begin
        k_int       = int'($signed(bus.in_k));
        run_len     = regime_len(k_int) - 1;
        sat_hi      = (k_int >= N - 2);
        sat_lo      = (k_int <= -(N - 1));
        base_vec    = {((k_int < 0) ? 1'b1 : 1'b0), tail, {(N-1){1'b0}}};
        shifted_vec = base_vec >> run_len;
        run_mask    = ~({LW{1'b1}} >> run_len);
        if (k_int >= 0) begin
            shifted_vec = shifted_vec | run_mask;
        end

        s1_flags_next.sign = bus.in_sign;
        s1_flags_next.zero = bus.in_zero;
        s1_flags_next.nar  = bus.in_nar;
        s1_flags_next.sat  = sat_hi | sat_lo;
        if (sat_hi) begin
            s1_body_next         = MAXPOS_W[N-2:0];
            s1_flags_next.guard  = 1'b0;
            s1_flags_next.sticky = 1'b0;
        end else if (sat_lo) begin
            s1_body_next         = MINPOS_W[N-2:0];
            s1_flags_next.guard  = 1'b0;
            s1_flags_next.sticky = 1'b0;
        end else begin
            s1_body_next         = shifted_vec[LW-1 -: N-1];
            s1_flags_next.guard  = shifted_vec[LW-N];
            s1_flags_next.sticky = (|shifted_vec[LW-N-1:0]) | bus.in_sticky;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_flags_reg <= '0;
            s1_body_reg  <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= bus.in_valid;
            if (bus.in_valid) begin
                s1_flags_reg <= s1_flags_next;
                s1_body_reg  <= s1_body_next;
            end
        end
    end

    posit_rne_round #(
        .N (N)
    ) u_round (
        .flags   (s1_flags_reg),
        .body    (s1_body_reg),
        .posit   (out_posit_next),
        .inexact (out_inexact_next),
        .sat     (out_sat_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg   <= 1'b0;
            out_posit_reg   <= '0;
            out_inexact_reg <= 1'b0;
            out_sat_reg     <= 1'b0;
        end else if (s2_load) begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_posit_reg   <= out_posit_next;
                out_inexact_reg <= out_inexact_next;
                out_sat_reg     <= out_sat_next;
            end
        end
    end

endmodule

// File: tb/tb_posit_round_pack.sv
// Self-checking bench for posit_round_pack (N=32, ES=3, FW=64) against a
// bit-list reference model of the posit packing rules.
module tb_posit_round_pack;
    localparam int N  = 32;
    localparam int ES = 3;
    localparam int FW = 64;
    localparam int KW = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    posit_round_pack_if #(.N(N), .ES(ES), .FW(FW), .KW(KW)) bus ();

    posit_round_pack #(.N(N), .ES(ES), .FW(FW), .KW(KW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    bit [31:0] exp_posit[$];
    bit        exp_inex[$];
    bit        exp_sat[$];
    bit [31:0] rcv_posit[$];
    bit        rcv_inex[$];
    bit        rcv_sat[$];

    // Reference: spell out regime, exponent and fraction bits as a list,
    // keep the first 31, round to nearest even, then negate.
    function automatic void ref_model(input bit s, input bit z, input bit nr, input int k,
                                      input bit [2:0] e, input bit [63:0] f, input bit st,
                                      output bit [31:0] word, output bit inex, output bit sat);
        bit q[$];
        longint unsigned mag;
        bit [31:0] m32;
        bit g;
        bit sk;
        word = 0; inex = 0; sat = 0; g = 0; sk = 0;
        if (nr) begin
            word = 32'h8000_0000;
            return;
        end
        if (z) return;
        if (k >= N - 2) begin
            mag = 64'h7FFF_FFFF; sat = 1;
        end else if (k <= -(N - 1)) begin
            mag = 1; sat = 1;
        end else begin
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) q.push_back(1'b1);
                q.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) q.push_back(1'b0);
                q.push_back(1'b1);
            end
            for (int i = 2; i >= 0; i--) q.push_back(e[i]);
            for (int i = 63; i >= 0; i--) q.push_back(f[i]);
            mag = 0;
            for (int i = 0; i < N - 1; i++) mag = (mag << 1) | longint'(q[i]);
            g  = q[N-1];
            sk = st;
            for (int i = N; i < q.size(); i++) sk |= q[i];
            if (g && (((mag & 1) != 0) || sk)) mag = mag + 1;
            if (mag > 64'h7FFF_FFFF) begin
                mag = 64'h7FFF_FFFF; sat = 1;
            end
        end
        inex = g | sk | sat;
        m32  = mag[31:0];
        word = s ? (32'd0 - m32) : m32;
    endfunction

    bit [31:0] m_w;
    bit        m_i;
    bit        m_s;
    always @(posedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            ref_model(bus.in_sign, bus.in_zero, bus.in_nar, int'($signed(bus.in_k)),
                      bus.in_exp, bus.in_frac, bus.in_sticky, m_w, m_i, m_s);
            exp_posit.push_back(m_w);
            exp_inex.push_back(m_i);
            exp_sat.push_back(m_s);
        end
        if (rst_n && bus.out_valid && bus.out_ready) begin
            rcv_posit.push_back(bus.out_posit);
            rcv_inex.push_back(bus.out_inexact);
            rcv_sat.push_back(bus.out_sat);
        end
    end

    task automatic clear_queues();
        exp_posit.delete(); exp_inex.delete(); exp_sat.delete();
        rcv_posit.delete(); rcv_inex.delete(); rcv_sat.delete();
    endtask

    task automatic set_fields(input bit s, input bit z, input bit nr, input int k,
                              input bit [2:0] e, input bit [63:0] f, input bit st);
        bus.in_sign = s; bus.in_zero = z; bus.in_nar = nr;
        bus.in_k = KW'(k); bus.in_exp = e; bus.in_frac = f; bus.in_sticky = st;
    endtask

    task automatic rand_fields();
        int k;
        k = int'($urandom_range(70)) - 35;
        set_fields(1'($urandom), $urandom_range(19) == 0, $urandom_range(29) == 0, k,
                   3'($urandom), {$urandom, $urandom}, 1'($urandom));
    endtask

    task automatic send(input bit s, input bit z, input bit nr, input int k,
                        input bit [2:0] e, input bit [63:0] f, input bit st);
        @(negedge clk);
        set_fields(s, z, nr, k, e, f, st);
        bus.in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (bus.in_ready) break;
            @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_rcv(input int n, output bit ok);
        ok = 0;
        for (int t = 0; t < 2000; t++) begin
            if (rcv_posit.size() >= n) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({bus.out_valid, bus.out_posit, bus.out_inexact, bus.out_sat} !== 35'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b p=%h i=%b s=%b want all zero",
                     bus.out_valid, bus.out_posit, bus.out_inexact, bus.out_sat);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_directed();
        localparam int NV = 17;
        bit        s[NV]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0};
        bit        z[NV]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
        bit        nr[NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        int        k[NV]  = '{0, 1, -1, 0, 0, 0, 0, 40, -40, 40, 29, 30, -30, -31, 0, 0, 0};
        bit [2:0]  e[NV]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0};
        bit [63:0] f[NV]  = '{0, 0, 0, 0, 64'h20_0000_0000, 64'h60_0000_0000,
                              64'h20_0000_0001, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF,
                              0, 0, 0, 0, 0, 0};
        bit        st[NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        bit [31:0] wp[NV] = '{32'h4000_0000, 32'h6000_0000, 32'h2000_0000, 32'hC000_0000,
                              32'h4000_0000, 32'h4000_0002, 32'h4000_0001, 32'h7FFF_FFFF,
                              32'h0000_0001, 32'h8000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                              32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000,
                              32'h4000_0000};
        bit        wi[NV] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0, 0, 1};
        bit        ws[NV] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0};
        bit ok;
        clear_queues();
        bus.out_ready = 1'b1;
        for (int i = 0; i < NV; i++) send(s[i], z[i], nr[i], k[i], e[i], f[i], st[i]);
        wait_rcv(NV, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL directed_count: got %0d results want %0d", rcv_posit.size(), NV);
        end
        for (int i = 0; i < NV && i < rcv_posit.size(); i++) begin
            total++;
            if ({rcv_posit[i], rcv_inex[i], rcv_sat[i]} !== {wp[i], wi[i], ws[i]}) begin
                bad++;
                $display("FAIL directed[%0d]: got posit=%h inex=%b sat=%b want posit=%h inex=%b sat=%b",
                         i, rcv_posit[i], rcv_inex[i], rcv_sat[i], wp[i], wi[i], ws[i]);
            end
        end
        $display("test_directed done: %0d vectors", NV);
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_queues();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rand_fields();
            bus.in_valid = 1'b1;
            #1;
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready[%0d]: got in_ready=%b want 1", i, bus.in_ready);
            end
            if (i == 1 || i == 2) begin
                total++;
                if (bus.out_valid !== (i == 2)) begin
                    bad++;
                    $display("FAIL b2b_latency[%0d]: got out_valid=%b want %b", i, bus.out_valid, i == 2);
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_rcv(8, ok);
        repeat (4) @(negedge clk);
        total++;
        if (rcv_posit.size() != 8 || exp_posit.size() != 8) begin
            bad++;
            $display("FAIL b2b_count: got %0d results want 8", rcv_posit.size());
        end
        while (rcv_posit.size() > 0 && exp_posit.size() > 0) begin
            total++;
            if ({rcv_posit[0], rcv_inex[0], rcv_sat[0]} !== {exp_posit[0], exp_inex[0], exp_sat[0]}) begin
                bad++;
                $display("FAIL b2b_data: got %h/%b/%b want %h/%b/%b", rcv_posit[0], rcv_inex[0],
                         rcv_sat[0], exp_posit[0], exp_inex[0], exp_sat[0]);
            end
            void'(rcv_posit.pop_front()); void'(rcv_inex.pop_front()); void'(rcv_sat.pop_front());
            void'(exp_posit.pop_front()); void'(exp_inex.pop_front()); void'(exp_sat.pop_front());
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_backpressure();
        int idx;
        bit take;
        bit ok;
        logic [31:0] held;
        clear_queues();
        idx = 0;
        held = '0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            @(negedge clk);
            bus.out_ready = (c >= 5);
            set_fields(0, 0, 0, idx, 3'($urandom), {$urandom, $urandom}, 0);
            bus.in_valid = 1'b1;
            #1;
            take = bus.in_ready;
            if (c == 2) held = bus.out_posit;
            if (c >= 2 && c <= 4) begin
                total++;
                if (bus.out_valid !== 1'b1 || bus.out_posit !== held) begin
                    bad++;
                    $display("FAIL stall_hold[%0d]: got v=%b posit=%h want v=1 posit=%h",
                             c, bus.out_valid, bus.out_posit, held);
                end
            end
            if (c == 4) begin
                total++;
                if (idx != 2 || bus.in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_ready: got accepted=%0d in_ready=%b want 2 0", idx, bus.in_ready);
                end
            end
            if (take) idx++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_rcv(4, ok);
        repeat (4) @(negedge clk);
        total++;
        if (rcv_posit.size() != 4 || exp_posit.size() != 4) begin
            bad++;
            $display("FAIL stall_count: got %0d results want 4", rcv_posit.size());
        end
        for (int i = 0; i < 4 && i < rcv_posit.size() && i < exp_posit.size(); i++) begin
            total++;
            if ({rcv_posit[i], rcv_inex[i]} !== {exp_posit[i], exp_inex[i]}) begin
                bad++;
                $display("FAIL stall_data[%0d]: got %h/%b want %h/%b", i, rcv_posit[i], rcv_inex[i],
                         exp_posit[i], exp_inex[i]);
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_reset_midstream();
        clear_queues();
        bus.out_ready = 1'b0;
        send(0, 0, 0, 3, 3'd1, 64'h1234_5678_9ABC_DEF0, 0);
        send(1, 0, 0, -2, 3'd5, 64'h0FED_CBA9_8765_4321, 0);
        total++;
        if (bus.out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_prefill: got out_valid=%b want 1", bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_posit !== 32'd0) begin
            bad++;
            $display("FAIL mid_reset: got out_valid=%b posit=%h want 0 00000000",
                     bus.out_valid, bus.out_posit);
        end
        clear_queues();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (rcv_posit.size() != 0 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_stale: got %0d outputs out_valid=%b want 0 0", rcv_posit.size(), bus.out_valid);
        end
        $display("test_reset_midstream done");
    endtask

    task automatic test_random();
        localparam int NT = 300;
        int sent;
        bit take;
        bit ok;
        int n;
        clear_queues();
        sent = 0;
        take = 0;
        for (int cyc = 0; cyc < 20000 && sent < NT; cyc++) begin
            @(negedge clk);
            if (take) begin
                sent++;
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(3) != 0);
            if (!bus.in_valid && sent < NT && $urandom_range(4) != 0) begin
                rand_fields();
                bus.in_valid = 1'b1;
            end
            #1;
            take = bus.in_valid && bus.in_ready;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_rcv(NT, ok);
        repeat (4) @(negedge clk);
        total++;
        if (sent != NT || rcv_posit.size() != NT || exp_posit.size() != NT) begin
            bad++;
            $display("FAIL random_count: got sent=%0d results=%0d want %0d", sent, rcv_posit.size(), NT);
        end
        n = (rcv_posit.size() < exp_posit.size()) ? rcv_posit.size() : exp_posit.size();
        for (int i = 0; i < n; i++) begin
            total++;
            if ({rcv_posit[i], rcv_inex[i], rcv_sat[i]} !== {exp_posit[i], exp_inex[i], exp_sat[i]}) begin
                bad++;
                $display("FAIL random[%0d]: got %h/%b/%b want %h/%b/%b", i, rcv_posit[i], rcv_inex[i],
                         rcv_sat[i], exp_posit[i], exp_inex[i], exp_sat[i]);
            end
        end
        $display("test_random done: %0d transactions", n);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_fields(0, 0, 0, 0, 3'd0, 64'd0, 0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
